pipeline_fetch: RTL and testbench

Instruction fetch stage of the pipelined core, directly upstream of the decode/control stage. Owns the PC register, issues word requests to instruction memory over a valid/ready handshake, and buffers in-order responses in a small FIFO. Presents {inst, pc, pc+4} to decode over a valid/ready handshake; decode extracts the opcode from this output. Accepts redirects from the stage that resolves next_pc_select (branch taken, JAL, JALR) and discards stale in-flight fetches.

---
 rtl/pipeline_fetch.sv | 164 ++++++++++++++++
 tb/tb_pipeline_fetch.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_fetch.sv
// Instruction fetch stage: owns the PC, requests words from imem, buffers
// in-order responses and hands {inst, pc, pc+4} to decode.
//
// Ports:
//   clock, reset_n                 core clock, async active-low reset
//   imem_req_valid/ready/addr      word fetch request (addr = pc)
//   imem_resp_valid/data           in-order responses, always accepted
//   redirect_valid/pc              one-cycle redirect from branch/jump resolve
//   if_valid/ready/inst/pc/pc4     FIFO head presented to decode
//   fetch_fault                    misaligned redirect target held in FAULT
//
// Optional: define PIPELINE_FETCH_ALIGN_CHECK_EN to trap misaligned
// redirect targets in FAULT; otherwise redirect_pc[1:0] is forced to 00.
module pipeline_fetch #(
    parameter int          XLEN       = 32,
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_inst,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc4,
    output logic            fetch_fault
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH, FAULT} state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [CW-1:0]   fifo_cnt;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            fault_pend;

    logic [XLEN-1:0] fifo_inst [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];

    logic            redirect_act;
    logic [XLEN-1:0] tgt_pc;
    logic            misalign;
    logic            pop;
    logic            req_fire;
    logic            resp_wr;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   drop_after;
    logic [CW:0]     inflight;
    logic [CW:0]     limit;

    assign redirect_act = redirect_valid && (state != BOOT);

`ifdef PIPELINE_FETCH_ALIGN_CHECK_EN
    assign tgt_pc   = redirect_pc;
    assign misalign = |redirect_pc[1:0];
`else
    assign tgt_pc   = redirect_pc & ~XLEN'(3);
    assign misalign = 1'b0;
`endif

    assign if_valid = (fifo_cnt != '0) && !redirect_act;
    assign pop      = if_valid && if_ready;

    // A slot freed by this cycle's pop counts as credit, so a 1-cycle
    // memory keeps the stage at one instruction per cycle.
    assign inflight = {1'b0, fifo_cnt} + {1'b0, outstanding};
    assign limit    = DEPTH_W + {{CW{1'b0}}, pop};

    assign imem_req_valid = (state == RUN) && !redirect_valid
                            && (inflight < limit);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // In RUN all outstanding requests are contiguous and end at pc-4,
    // so the oldest one (the one responding now) is pc - 4*outstanding.
    assign resp_pc    = pc - (XLEN'(outstanding) << 2);
    assign resp_wr    = imem_resp_valid && (state == RUN) && !redirect_act;
    assign drop_after = outstanding - CW'(imem_resp_valid);

    assign if_inst = fifo_inst[rd_ptr];
`ifdef PIPELINE_FETCH_ALIGN_CHECK_EN
    assign if_pc       = (state == FAULT) ? pc : fifo_pc[rd_ptr];
    assign fetch_fault = (state == FAULT);
`else
    assign if_pc       = fifo_pc[rd_ptr];
    assign fetch_fault = 1'b0;
`endif
    assign if_pc4 = if_pc + XLEN'(4);

    always_ff @(posedge clock) begin
        if (resp_wr) begin
            fifo_inst[wr_ptr] <= imem_resp_data;
            fifo_pc[wr_ptr]   <= resp_pc;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= BOOT;
            pc          <= XLEN'(RESET_PC);
            fifo_cnt    <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fault_pend  <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(req_fire)
                           - CW'(imem_resp_valid);
            if (redirect_act) begin
                pc         <= tgt_pc;
                fifo_cnt   <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                // In FLUSH outstanding equals drop_cnt, so this also
                // keeps the remaining count for a redirect during FLUSH.
                drop_cnt   <= drop_after;
                fault_pend <= misalign;
                if (drop_after != '0)
                    state <= FLUSH;
                else if (misalign)
                    state <= FAULT;
                else
                    state <= RUN;
            end else begin
                if (req_fire)
                    pc <= pc + XLEN'(4);
                if (resp_wr)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                fifo_cnt <= fifo_cnt + CW'(resp_wr) - CW'(pop);
                unique case (state)
                    BOOT:  state <= RUN;
                    RUN:   state <= RUN;
                    FLUSH: begin
                        if (imem_resp_valid) begin
                            drop_cnt <= drop_cnt - CW'(1);
                            if (drop_cnt == CW'(1))
                                state <= fault_pend ? FAULT : RUN;
                        end
                    end
                    FAULT: state <= FAULT;
                    default: state <= BOOT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipeline_fetch.sv
// Bench for pipeline_fetch: behavioural imem with programmable latency and
// a scoreboard of expected {pc, inst} pushed at request, popped at decode.
module tb_pipeline_fetch;

    logic        clock;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        fetch_fault;

    pipeline_fetch dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_inst         (if_inst),
        .if_pc           (if_pc),
        .if_pc4          (if_pc4),
        .fetch_fault     (fetch_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] exq[$];

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc_n = 0;
    int          lat = 1;
    int          pops = 0;
    int          first_fire = -1;
    int          first_resp = -1;
    int          first_valid = -1;
    logic [31:0] model_pc = 32'h0040_0000;
    bit          model_fault = 0;
    bit          arm_first = 0;
    logic [31:0] first_pc;

    logic        obs_req_valid;
    logic [31:0] obs_req_addr;
    logic        obs_if_valid;
    logic [31:0] obs_if_pc;
    logic [31:0] obs_if_inst;
    logic        obs_fault;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        bit          resp;
        logic [31:0] e;
        resp = (mq.size() > 0) && (mq[0].due <= cyc_n);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? word(mq[0].addr) : 32'h0;
        @(negedge clock);
        obs_req_valid = imem_req_valid;
        obs_req_addr  = imem_req_addr;
        obs_if_valid  = if_valid;
        obs_if_pc     = if_pc;
        obs_if_inst   = if_inst;
        obs_fault     = fetch_fault;
        if (resp && first_resp < 0) first_resp = cyc_n;
        if (if_valid && first_valid < 0) first_valid = cyc_n;
        if (redirect_valid) begin
            chk("redir_req_valid", {31'b0, imem_req_valid}, 32'h0);
            chk("redir_if_valid", {31'b0, if_valid}, 32'h0);
            exq.delete();
`ifdef PIPELINE_FETCH_ALIGN_CHECK_EN
            model_pc    = redirect_pc;
            model_fault = |redirect_pc[1:0];
`else
            model_pc    = redirect_pc & ~32'h3;
            model_fault = 0;
`endif
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                if (first_fire < 0) first_fire = cyc_n;
                if (model_fault)
                    chk("fault_req", {31'b0, imem_req_valid}, 32'h0);
                chk("req_addr", imem_req_addr, model_pc);
                mq.push_back('{imem_req_addr, cyc_n + lat});
                exq.push_back(model_pc);
                model_pc = model_pc + 32'd4;
            end
            if (if_valid && if_ready) begin
                pops++;
                if (arm_first) begin
                    first_pc  = if_pc;
                    arm_first = 0;
                end
                if (exq.size() == 0) begin
                    chk("pop_unexpected", {31'b0, if_valid}, 32'h0);
                end else begin
                    e = exq.pop_front();
                    chk("if_pc", if_pc, e);
                    chk("if_inst", if_inst, word(e));
                    chk("if_pc4", if_pc4, e + 32'd4);
                end
            end
        end
        if (resp) void'(mq.pop_front());
        @(posedge clock);
        cyc_n++;
        #1;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        arm_first      = 1;
        first_pc       = 32'hxxxx_xxxx;
        cyc();
        redirect_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] held_pc;
        logic [31:0] held_inst;
        int          p0;

        reset_n         = 1'b0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        if_ready        = 1'b1;

        // reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
        chk("rst_addr", imem_req_addr, 32'h0040_0000);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cyc_n   = 1;

        // boot, first fetch, steady throughput with 1-cycle memory
        for (int i = 0; i < 30; i++) begin
            if (i == 10) p0 = pops;
            cyc();
        end
        chk("first_req_cycle", first_fire, 2);
        chk("resp_to_valid", first_valid, first_resp + 1);
        chk("throughput", pops - p0, 20);

        // decode stall: FIFO fills to two entries and holds its head
        if_ready = 1'b0;
        cyc();
        held_pc   = obs_if_pc;
        held_inst = obs_if_inst;
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("stall_pc", obs_if_pc, held_pc);
            chk("stall_inst", obs_if_inst, held_inst);
        end
        chk("full_no_req", {31'b0, obs_req_valid}, 32'h0);
        chk("buffered", exq.size(), 2);
        chk("none_inflight", mq.size(), 0);
        if_ready = 1'b1;
        repeat (10) cyc();

        // memory backpressure: request held steady, pc frozen
        imem_req_ready = 1'b0;
        cyc();
        held_pc = obs_req_addr;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_addr", obs_req_addr, held_pc);
            chk("bp_valid", {31'b0, obs_req_valid}, 32'h1);
        end
        chk("bp_model_pc", obs_req_addr, model_pc);

        // 3-cycle memory, two outstanding, redirect drops both
        lat = 3;
        imem_req_ready = 1'b1;
        repeat (2) cyc();
        chk("two_outstanding", mq.size(), 2);
        redirect(32'h0040_0100);
        cyc();
        chk("flush_no_req1", {31'b0, obs_req_valid}, 32'h0);
        cyc();
        chk("flush_no_req2", {31'b0, obs_req_valid}, 32'h0);
        repeat (15) cyc();
        chk("flush_first_pc", first_pc, 32'h0040_0100);

        // redirect coinciding with a response and a decode pop
        lat = 1;
        repeat (10) cyc();
        redirect(32'h0040_0040);
        cyc();
        chk("post_redir_valid", {31'b0, obs_if_valid}, 32'h0);
        repeat (10) cyc();
        chk("redir_first_pc", first_pc, 32'h0040_0040);

        // misaligned redirect target
        redirect(32'h0040_0102);
`ifdef PIPELINE_FETCH_ALIGN_CHECK_EN
        repeat (5) cyc();
        chk("fault_set", {31'b0, obs_fault}, 32'h1);
        chk("fault_no_req", {31'b0, obs_req_valid}, 32'h0);
        chk("fault_if_valid", {31'b0, obs_if_valid}, 32'h0);
        chk("fault_if_pc", obs_if_pc, 32'h0040_0102);
`else
        repeat (10) cyc();
        chk("masked_first_pc", first_pc, 32'h0040_0100);
        chk("no_fault", {31'b0, obs_fault}, 32'h0);
`endif
        redirect(32'h0040_0200);
        repeat (10) cyc();
        chk("resume_first_pc", first_pc, 32'h0040_0200);
        chk("fault_clear", {31'b0, obs_fault}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
